// File: rtl/ram_port_arbiter.sv
// Three-requester arbiter in front of a dual-port (read/write) RAM.
// Requester 0 has priority, 1 and 2 share round-robin, with anti-starvation.
`timescale 1ns/1ps

module ram_port_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              rq_req,
    input  logic [2:0]              rq_we,
    input  logic [3*ADDR_WIDTH-1:0] rq_addr,
    input  logic [3*DATA_WIDTH-1:0] rq_wdata,
    input  logic [3*DATA_WIDTH-1:0] rq_wmask_n,
    output logic [2:0]              rq_ack,
    output logic [2:0]              rq_rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ADDR_WIDTH-1:0]   ram_adr,
    output logic                    ram_cer,
    output logic                    ram_re,
    input  logic [DATA_WIDTH-1:0]   ram_do,
    output logic [ADDR_WIDTH-1:0]   ram_adw,
    output logic [DATA_WIDTH-1:0]   ram_di,
    output logic                    ram_cew,
    output logic                    ram_we,
    output logic [DATA_WIDTH-1:0]   ram_mask_n
);

    logic                  pref_two;
    logic [3:0]            starve_cnt;
    logic [2:0]            rvalid_q;
    logic [ADDR_WIDTH-1:0] adr_q;

    logic                  hi_req;
    logic                  force_hi;
    logic                  rr_two;
    logic [2:0]            grant;
    logic [1:0]            gidx;
    logic                  rd_grant;
    logic                  wr_grant;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [DATA_WIDTH-1:0] sel_mask;

    // Grant selection: requester 0 first unless 1/2 have waited too long
    always_comb begin
        hi_req   = |rq_req[2:1];
        rr_two   = rq_req[2] && (!rq_req[1] || pref_two);
        force_hi = hi_req && (starve_cnt == 4'(STARVE_LIMIT));
        grant    = 3'b000;
        if (!reset) begin
            if (rq_req[0] && !force_hi) begin
                grant = 3'b001;
            end else if (hi_req) begin
                grant = rr_two ? 3'b100 : 3'b010;
            end
        end
        rd_grant = |(grant & ~rq_we);
        wr_grant = |(grant &  rq_we);
    end

    // Index of the granted requester, used to pick its request slices
    always_comb begin
        unique case (1'b1)
            grant[2]: gidx = 2'd2;
            grant[1]: gidx = 2'd1;
            default:  gidx = 2'd0;
        endcase
    end

    // Slice mux for the granted requester's address, data and mask
    always_comb begin
        unique case (gidx)
            2'd2: begin
                sel_addr  = rq_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = rq_wdata[2*DATA_WIDTH +: DATA_WIDTH];
                sel_mask  = rq_wmask_n[2*DATA_WIDTH +: DATA_WIDTH];
            end
            2'd1: begin
                sel_addr  = rq_addr[ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = rq_wdata[DATA_WIDTH +: DATA_WIDTH];
                sel_mask  = rq_wmask_n[DATA_WIDTH +: DATA_WIDTH];
            end
            default: begin
                sel_addr  = rq_addr[0 +: ADDR_WIDTH];
                sel_wdata = rq_wdata[0 +: DATA_WIDTH];
                sel_mask  = rq_wmask_n[0 +: DATA_WIDTH];
            end
        endcase
    end

    // RAM port drive; read address holds between reads
    always_comb begin
        rq_ack     = grant;
        rq_rvalid  = rvalid_q & {3{~reset}};
        rdata      = ram_do;
        ram_cer    = rd_grant;
        ram_re     = rd_grant;
        ram_adr    = rd_grant ? sel_addr : adr_q;
        ram_cew    = wr_grant;
        ram_we     = wr_grant;
        ram_adw    = wr_grant ? sel_addr : '0;
        ram_di     = wr_grant ? sel_wdata : '0;
        ram_mask_n = wr_grant ? sel_mask : '1;
    end

    // Arbitration state, read-valid pipeline and held read address
    always_ff @(posedge clk) begin
        if (reset) begin
            pref_two   <= 1'b0;
            starve_cnt <= 4'd0;
            rvalid_q   <= 3'b000;
            adr_q      <= '0;
        end else begin
            rvalid_q <= grant & ~rq_we;
            if (rd_grant) begin
                adr_q <= sel_addr;
            end
            if (|grant[2:1]) begin
                pref_two <= grant[1];
            end
            if (!hi_req || |grant[2:1]) begin
                starve_cnt <= 4'd0;
            end else if (grant[0]) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic
// checked against a rule-level arbitration and memory model.
`timescale 1ns/1ps

module tb_ram_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int SL = 4;

    logic            clk;
    logic            reset;
    logic [2:0]      rq_req;
    logic [2:0]      rq_we;
    logic [3*AW-1:0] rq_addr;
    logic [3*DW-1:0] rq_wdata;
    logic [3*DW-1:0] rq_wmask_n;
    logic [2:0]      rq_ack;
    logic [2:0]      rq_rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   ram_adr;
    logic            ram_cer;
    logic            ram_re;
    logic [DW-1:0]   ram_do;
    logic [AW-1:0]   ram_adw;
    logic [DW-1:0]   ram_di;
    logic            ram_cew;
    logic            ram_we;
    logic [DW-1:0]   ram_mask_n;

    ram_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .rq_req(rq_req), .rq_we(rq_we), .rq_addr(rq_addr),
        .rq_wdata(rq_wdata), .rq_wmask_n(rq_wmask_n),
        .rq_ack(rq_ack), .rq_rvalid(rq_rvalid), .rdata(rdata),
        .ram_adr(ram_adr), .ram_cer(ram_cer), .ram_re(ram_re),
        .ram_do(ram_do), .ram_adw(ram_adw), .ram_di(ram_di),
        .ram_cew(ram_cew), .ram_we(ram_we), .ram_mask_n(ram_mask_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM attached to the DUT: registered read, masked write
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_cew && ram_we)
            ram[ram_adw] <= (ram[ram_adw] & ram_mask_n) | (ram_di & ~ram_mask_n);
        if (ram_cer && ram_re)
            ram_do <= ram[ram_adr];
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_cnt;
    int            m_pref;
    logic [2:0]    m_rv;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] m_adr;
    bit            m_adr_ok;

    int tests;
    int fails;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input logic [2:0] r);
        bit hi;
        int rr;
        hi = r[1] || r[2];
        if (r[1] && r[2]) rr = m_pref;
        else rr = r[1] ? 1 : 2;
        if (hi && m_cnt == SL) return rr;
        if (r[0]) return 0;
        if (hi) return rr;
        return -1;
    endfunction

    task automatic set_port(input int i, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] m);
        rq_we[i]             = we;
        rq_addr[i*AW +: AW]  = a;
        rq_wdata[i*DW +: DW] = d;
        rq_wmask_n[i*DW +: DW] = m;
    endtask

    // One clock cycle: check outputs against the model, then advance it.
    // want = -2 means no specific grant index is demanded.
    task automatic cycle(input int want, output int g);
        int            dg;
        bit            rd;
        bit            wr;
        bit            hi;
        logic [2:0]    exp_ack;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] m;
        #1;
        g  = reset ? -1 : model_grant(rq_req);
        rd = (g >= 0) && !rq_we[g];
        wr = (g >= 0) && rq_we[g];
        a  = '0;
        d  = '0;
        m  = '1;
        if (g >= 0) begin
            a = rq_addr[g*AW +: AW];
            d = rq_wdata[g*DW +: DW];
            m = rq_wmask_n[g*DW +: DW];
        end
        exp_ack = (g >= 0) ? (3'b001 << g) : 3'b000;
        check("ack", 64'(rq_ack), 64'(exp_ack));
        if (want != -2) begin
            if (rq_ack == 3'b001) dg = 0;
            else if (rq_ack == 3'b010) dg = 1;
            else if (rq_ack == 3'b100) dg = 2;
            else dg = -1;
            check("grant_seq", 64'(dg), 64'(want));
        end
        check("enables", 64'({ram_cer, ram_re, ram_cew, ram_we}),
              64'({rd, rd, wr, wr}));
        if (rd) check("ram_adr", 64'(ram_adr), 64'(a));
        else if (m_adr_ok) check("adr_hold", 64'(ram_adr), 64'(m_adr));
        if (wr) begin
            check("ram_adw", 64'(ram_adw), 64'(a));
            check("ram_di", 64'(ram_di), 64'(d));
            check("ram_mask", 64'(ram_mask_n), 64'(m));
        end else begin
            check("mask_idle", 64'(ram_mask_n), 64'({DW{1'b1}}));
        end
        check("rvalid", 64'(rq_rvalid), reset ? 64'd0 : 64'(m_rv));
        if (!reset && m_rv != 3'b000)
            check("rdata", 64'(rdata), 64'(m_rdata));
        @(posedge clk);
        if (reset) begin
            m_cnt    = 0;
            m_pref   = 1;
            m_rv     = 3'b000;
            m_adr_ok = 0;
        end else begin
            hi = rq_req[1] || rq_req[2];
            if (!hi || g == 1 || g == 2) m_cnt = 0;
            else if (g == 0) m_cnt++;
            if (g == 1) m_pref = 2;
            else if (g == 2) m_pref = 1;
            m_rv = rd ? (3'b001 << g) : 3'b000;
            if (rd) begin
                m_rdata  = ref_mem[a];
                m_adr    = a;
                m_adr_ok = 1;
            end
            if (wr) ref_mem[a] = (ref_mem[a] & m) | (d & ~m);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        int g;
        reset  = 1'b1;
        rq_req = 3'b000;
        cycle(-1, g);
        cycle(-1, g);
        reset  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int seq20 [11];
        bit [2:0] pend;
        logic [DW-1:0] v;
        seq20 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0};
        tests = 0;
        fails = 0;
        m_cnt = 0;
        m_pref = 1;
        m_rv = 3'b000;
        m_rdata = '0;
        m_adr = '0;
        m_adr_ok = 0;
        reset = 1'b1;
        rq_req = 3'b000;
        rq_we = 3'b000;
        rq_addr = '0;
        rq_wdata = '0;
        rq_wmask_n = '1;
        ram_do = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            v = DW'($urandom);
            ram[i] = v;
            ref_mem[i] = v;
        end
        @(negedge clk);
        do_reset();

        // single read of a known word
        ram[12'h123] = 16'hBEEF;
        ref_mem[12'h123] = 16'hBEEF;
        set_port(1, 1'b0, 12'h123, '0, '1);
        rq_req = 3'b010;
        cycle(1, g);
        rq_req = 3'b000;
        #1;
        check("single_rvalid", 64'(rq_rvalid), 64'(3'b010));
        check("single_rdata", 64'(rdata), 64'(16'hBEEF));
        cycle(-1, g);

        // masked write followed immediately by read of the same word
        ram[12'h050] = 16'h1234;
        ref_mem[12'h050] = 16'h1234;
        set_port(2, 1'b1, 12'h050, 16'hFFFF, 16'h00FF);
        rq_req = 3'b100;
        cycle(2, g);
        set_port(2, 1'b0, 12'h050, '0, '1);
        cycle(2, g);
        rq_req = 3'b000;
        #1;
        check("mask_rvalid", 64'(rq_rvalid), 64'(3'b100));
        check("mask_rdata", 64'(rdata), 64'(16'hFF34));
        cycle(-1, g);

        // starvation pattern with all three requesting
        do_reset();
        set_port(0, 1'b0, 12'h001, '0, '1);
        set_port(1, 1'b0, 12'h002, '0, '1);
        set_port(2, 1'b0, 12'h003, '0, '1);
        rq_req = 3'b111;
        for (int i = 0; i < 11; i++) cycle(seq20[i], g);

        // round-robin between 1 and 2
        do_reset();
        rq_req = 3'b110;
        for (int i = 0; i < 4; i++) cycle((i % 2 == 0) ? 1 : 2, g);

        // reset arriving right after a read grant
        do_reset();
        rq_req = 3'b001;
        cycle(0, g);
        reset = 1'b1;
        rq_req = 3'b111;
        cycle(-1, g);
        cycle(-1, g);
        reset = 1'b0;
        rq_req = 3'b110;
        cycle(1, g);
        rq_req = 3'b000;
        cycle(-1, g);

        // random traffic with hold-until-ack, withdrawals and resets
        pend = 3'b000;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[i] = 1'b1;
                        set_port(i, 1'($urandom_range(0, 1)),
                                 AW'($urandom_range(0, 15)),
                                 DW'($urandom), DW'($urandom));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            reset  = ($urandom_range(0, 99) == 0);
            rq_req = pend;
            cycle(-2, g);
            if (g >= 0) pend[g] = 1'b0;
        end
        reset  = 1'b0;
        rq_req = 3'b000;
        cycle(-1, g);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, RAM word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, RAM word width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, consecutive requester-0 grants tolerated while requester 1 or 2 waits (range 1..15).
REQ-004 The block SHALL have these ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rq_req  in  3  access request, bit N = requester N; held high until acked.
- rq_we  in  3  bit N: 1 = write, 0 = read.
- rq_addr  in  3*ADDR_WIDTH  packed word addresses, slice N = requester N.
- rq_wdata  in  3*DATA_WIDTH  packed write data.
- rq_wmask_n  in  3*DATA_WIDTH  packed active-low per-bit write masks.
- rq_ack  out  3  one-hot; bit N high in the cycle requester N is granted.
- rq_rvalid  out  3  one-hot; bit N high the cycle after a read grant to N.
- rdata  out  DATA_WIDTH  read data, valid when any rq_rvalid bit is high.
- ram_adr  out  ADDR_WIDTH  RAM read address.
- ram_cer  out  1  RAM read clock enable.
- ram_re  out  1  RAM read enable.
- ram_do  in  DATA_WIDTH  RAM registered read data.
- ram_adw  out  ADDR_WIDTH  RAM write address.
- ram_di  out  DATA_WIDTH  RAM write data.
- ram_cew  out  1  RAM write clock enable.
- ram_we  out  1  RAM write enable.
- ram_mask_n  out  DATA_WIDTH  RAM active-low write mask.

Function
REQ-005 At most one requester SHALL be granted per cycle; rq_ack SHALL be combinational from current requests and registered arbitration state.
REQ-006 Requester 0 SHALL have fixed highest priority except when the starvation counter equals STARVE_LIMIT.
REQ-007 Requesters 1 and 2 SHALL share round-robin priority: after granting 1, prefer 2; after granting 2, prefer 1; pointer changes only on a grant to 1 or 2.
REQ-008 The 4-bit starvation counter SHALL increment on each grant to requester 0 while rq_req[1] or rq_req[2] is high, and clear on any grant to 1 or 2 or in any cycle with rq_req[2:1] == 0.
REQ-009 When the counter equals STARVE_LIMIT and rq_req[2:1] != 0, the grant SHALL go to the round-robin winner of 1/2 even if rq_req[0] is high.
REQ-010 On a read grant to N: ram_adr = slice N of rq_addr, ram_cer = ram_re = 1 in the same cycle; otherwise ram_cer = ram_re = 0 and ram_adr holds its last value.
REQ-011 On a write grant to N: ram_adw/ram_di/ram_mask_n = slice N of rq_addr/rq_wdata/rq_wmask_n, ram_cew = ram_we = 1 in the same cycle; otherwise ram_cew = ram_we = 0 and ram_mask_n = all ones.
REQ-012 rq_rvalid SHALL be a register: bit N = 1 exactly one cycle after a read grant to N; rdata SHALL pass ram_do through combinationally, giving read latency 1 cycle from ack.
REQ-013 Write then read of the same address in consecutive cycles SHALL return the new data; the arbiter adds no bypass.
REQ-014 No requests pending: rq_ack = 0 and all RAM enables = 0; idle cycles do not move the round-robin pointer.
REQ-015 A requester dropping rq_req before ack SHALL be treated as withdrawn, with no side effect.

Reset
REQ-016 While reset is high: rq_ack = 0, rq_rvalid = 0, RAM enables = 0, ram_mask_n = all ones, counter = 0, round-robin pointer prefers requester 1; requests are ignored.
REQ-017 A read granted in the cycle before reset asserts SHALL NOT produce rq_rvalid after reset.

Verification
REQ-018 Single read: rq_req = 3'b010, rq_addr[1] = 12'h123, RAM word = 16'hBEEF -> rq_ack = 3'b010 that cycle, rq_rvalid = 3'b010 and rdata = 16'hBEEF next cycle.
REQ-019 Masked write: requester 2 writes 16'hFFFF with mask_n 16'h00FF to a word holding 16'h1234, then reads it -> read returns 16'hFF34.
REQ-020 Starvation: rq_req = 3'b111 held continuously, STARVE_LIMIT = 4 -> grant sequence 0,0,0,0,1,0,0,0,0,2,0,...
REQ-021 Round-robin: rq_req = 3'b110 held -> grants alternate 1,2,1,2, starting with 1 after reset.
REQ-022 Reset mid-read: read grant to requester 0, reset asserted the next cycle for 2 cycles -> rq_rvalid stays 0, all RAM enables 0, first post-reset grant with 3'b110 goes to 1.
